// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - CSR addresses, exception codes, field positions and write-merge helper
package csr_regfile_pkg;

    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_ECFG      = 14'h004;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_BADV      = 14'h007;
    localparam logic [13:0] CSR_EENTRY    = 14'h00C;
    localparam logic [13:0] CSR_TLBIDX    = 14'h010;
    localparam logic [13:0] CSR_TLBEHI    = 14'h011;
    localparam logic [13:0] CSR_ASID      = 14'h018;
    localparam logic [13:0] CSR_SAVE0     = 14'h030;
    localparam logic [13:0] CSR_SAVE1     = 14'h031;
    localparam logic [13:0] CSR_SAVE2     = 14'h032;
    localparam logic [13:0] CSR_SAVE3     = 14'h033;
    localparam logic [13:0] CSR_TID       = 14'h040;
    localparam logic [13:0] CSR_TCFG      = 14'h041;
    localparam logic [13:0] CSR_TVAL      = 14'h042;
    localparam logic [13:0] CSR_TICLR     = 14'h044;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int CRMD_PLV       = 0;
    localparam int CRMD_IE        = 2;
    localparam int CRMD_DA        = 3;
    localparam int CRMD_PG        = 4;
    localparam int CRMD_DATF      = 5;
    localparam int CRMD_DATM      = 7;
    localparam int ESTAT_IS_TI    = 11;
    localparam int ESTAT_IS_IPI   = 12;
    localparam int ESTAT_ECODE    = 16;
    localparam int ESTAT_ESUBCODE = 22;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wvalue);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// rtl/csr_regfile_if.sv - CSR read/write access bus between WB stage and the register file
interface csr_regfile_if;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_rvalue;

    modport master (output csr_num, csr_we, csr_wmask, csr_wvalue, input csr_rvalue);
    modport slave  (input csr_num, csr_we, csr_wmask, csr_wvalue, output csr_rvalue);
endinterface

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TCFG/TVAL countdown timer and the timer interrupt flag
module csr_timer #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we,
    input  logic [31:0] tcfg_wdata,
    input  logic        ticlr_we,
    output logic [31:0] tcfg_rdata,
    output logic [31:0] tval_rdata,
    output logic        timer_int
);
    logic               en;
    logic               periodic;
    logic [TIMER_W-3:0] initval;
    logic [TIMER_W-1:0] tval;
    logic               fire;

    assign fire = en && (tval == TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            en        <= 1'b0;
            periodic  <= 1'b0;
            initval   <= '0;
            tval      <= '0;
            timer_int <= 1'b0;
        end else begin
            if (tcfg_we) begin
                en       <= tcfg_wdata[0];
                periodic <= tcfg_wdata[1];
                initval  <= tcfg_wdata[TIMER_W-1:2];
            end
            if (tcfg_we && tcfg_wdata[0])
                tval <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
            else if (en && tval != '0)
                tval <= fire ? (periodic ? {initval, 2'b00} : '0) : tval - TIMER_W'(1);
            // A fire on the same edge as a TICLR clear keeps the flag set
            if (fire)
                timer_int <= 1'b1;
            else if (ticlr_we)
                timer_int <= 1'b0;
        end
    end

    assign tcfg_rdata = 32'({initval, periodic, en});
    assign tval_rdata = 32'(tval);

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - architectural CSR file with exception entry/return, TLB CSRs and interrupt request
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int  TLBNUM  = 16,
    parameter int  TIMER_W = 32,
    localparam int IDX_W   = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    csr_regfile_if.slave     bus,
    input  logic             wb_ex,
    input  logic [5:0]       wb_ecode,
    input  logic [8:0]       wb_esubcode,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_vaddr,
    input  logic             ertn_flush,
    output logic [31:0]      ex_entry,
    output logic             has_int,
    input  logic [7:0]       hw_int_in,
    input  logic             ipi_int_in,
    input  logic             tlbsrch_we,
    input  logic             tlbsrch_hit,
    input  logic [IDX_W-1:0] tlbsrch_hit_index,
    input  logic             tlbrd_we,
    input  logic             tlbrd_valid,
    input  logic [18:0]      tlbrd_vppn,
    input  logic [5:0]       tlbrd_ps,
    input  logic [9:0]       tlbrd_asid,
    output logic [IDX_W-1:0] csr_tlbidx_index,
    output logic [9:0]       csr_asid,
    output logic [18:0]      csr_tlbehi_vppn,
    output logic [1:0]       csr_crmd_plv
);
    logic [1:0]       crmd_plv, crmd_datf, crmd_datm;
    logic             crmd_ie, crmd_da, crmd_pg;
    logic [1:0]       prmd_pplv;
    logic             prmd_pie;
    logic [12:0]      ecfg_lie;
    logic [1:0]       estat_sw;
    logic [7:0]       estat_hw;
    logic             estat_ipi;
    logic [5:0]       estat_ecode;
    logic [8:0]       estat_esubcode;
    logic [12:0]      estat_is;
    logic [31:0]      era, badv, tid;
    logic [31:0]      save [4];
    logic [25:0]      eentry_va, tlbrentry_pa;
    logic [IDX_W-1:0] tlbidx_index;
    logic [5:0]       tlbidx_ps;
    logic             tlbidx_ne;
    logic [18:0]      tlbehi_vppn;
    logic [9:0]       asid;

    logic [31:0]      rdata, wr_merged, tcfg_rdata, tval_rdata;
    logic             timer_int, ex_tlbr, ex_page, ex_badv_va, ex_badv_pc;

    assign estat_is = {estat_ipi, timer_int, 1'b0, estat_hw, estat_sw};

    always_comb begin
        rdata = '0;
        case (bus.csr_num)
            CSR_CRMD: begin
                rdata[CRMD_PLV +: 2]  = crmd_plv;
                rdata[CRMD_IE]        = crmd_ie;
                rdata[CRMD_DA]        = crmd_da;
                rdata[CRMD_PG]        = crmd_pg;
                rdata[CRMD_DATF +: 2] = crmd_datf;
                rdata[CRMD_DATM +: 2] = crmd_datm;
            end
            CSR_PRMD:  rdata[2:0] = {prmd_pie, prmd_pplv};
            CSR_ECFG:  rdata[12:0] = ecfg_lie;
            CSR_ESTAT: begin
                rdata[12:0]                = estat_is;
                rdata[ESTAT_ECODE +: 6]    = estat_ecode;
                rdata[ESTAT_ESUBCODE +: 9] = estat_esubcode;
            end
            CSR_ERA:       rdata = era;
            CSR_BADV:      rdata = badv;
            CSR_EENTRY:    rdata = {eentry_va, 6'b0};
            CSR_TLBIDX: begin
                rdata[IDX_W-1:0] = tlbidx_index;
                rdata[29:24]     = tlbidx_ps;
                rdata[31]        = tlbidx_ne;
            end
            CSR_TLBEHI:    rdata = {tlbehi_vppn, 13'b0};
            CSR_ASID:      rdata[9:0] = asid;
            CSR_SAVE0:     rdata = save[0];
            CSR_SAVE1:     rdata = save[1];
            CSR_SAVE2:     rdata = save[2];
            CSR_SAVE3:     rdata = save[3];
            CSR_TID:       rdata = tid;
            CSR_TCFG:      rdata = tcfg_rdata;
            CSR_TVAL:      rdata = tval_rdata;
            CSR_TLBRENTRY: rdata = {tlbrentry_pa, 6'b0};
            default:       rdata = '0;
        endcase
    end

    assign bus.csr_rvalue = rdata;
    assign wr_merged      = csr_merge(rdata, bus.csr_wmask, bus.csr_wvalue);

    assign ex_tlbr    = (wb_ecode == ECODE_TLBR);
    assign ex_page    = (wb_ecode == ECODE_PIL) || (wb_ecode == ECODE_PIS) || (wb_ecode == ECODE_PIF)
                     || (wb_ecode == ECODE_PME) || (wb_ecode == ECODE_PPI);
    assign ex_badv_va = ex_page || ex_tlbr || (wb_ecode == ECODE_ALE);
    assign ex_badv_pc = (wb_ecode == ECODE_ADE) && (wb_esubcode == 9'd0);

    csr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tcfg_we    (bus.csr_we && bus.csr_num == CSR_TCFG),
        .tcfg_wdata (wr_merged),
        .ticlr_we   (bus.csr_we && bus.csr_num == CSR_TICLR && wr_merged[0]),
        .tcfg_rdata (tcfg_rdata),
        .tval_rdata (tval_rdata),
        .timer_int  (timer_int)
    );

    // Later statements override earlier ones: wb_ex > ertn_flush > TLB ops > csr_we
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_plv <= '0; crmd_ie <= 1'b0; crmd_da <= 1'b1; crmd_pg <= 1'b0;
            crmd_datf <= '0; crmd_datm <= '0;
            prmd_pplv <= '0; prmd_pie <= 1'b0;
            ecfg_lie <= '0;
            estat_sw <= '0; estat_hw <= '0; estat_ipi <= 1'b0;
            estat_ecode <= '0; estat_esubcode <= '0;
            era <= '0; badv <= '0; tid <= '0;
            for (int i = 0; i < 4; i++) save[i] <= '0;
            eentry_va <= '0; tlbrentry_pa <= '0;
            tlbidx_index <= '0; tlbidx_ps <= '0; tlbidx_ne <= 1'b0;
            tlbehi_vppn <= '0; asid <= '0;
        end else begin
            estat_hw  <= hw_int_in;
            estat_ipi <= ipi_int_in;
            if (bus.csr_we) begin
                case (bus.csr_num)
                    CSR_CRMD: begin
                        crmd_plv  <= wr_merged[CRMD_PLV +: 2];
                        crmd_ie   <= wr_merged[CRMD_IE];
                        crmd_da   <= wr_merged[CRMD_DA];
                        crmd_pg   <= wr_merged[CRMD_PG];
                        crmd_datf <= wr_merged[CRMD_DATF +: 2];
                        crmd_datm <= wr_merged[CRMD_DATM +: 2];
                    end
                    CSR_PRMD: begin
                        prmd_pplv <= wr_merged[1:0];
                        prmd_pie  <= wr_merged[2];
                    end
                    CSR_ECFG:  ecfg_lie <= wr_merged[12:0];
                    CSR_ESTAT: begin
                        estat_sw       <= wr_merged[1:0];
                        estat_esubcode <= wr_merged[ESTAT_ESUBCODE +: 9];
                    end
                    CSR_ERA:    era <= wr_merged;
                    CSR_BADV:   badv <= wr_merged;
                    CSR_EENTRY: eentry_va <= wr_merged[31:6];
                    CSR_TLBIDX: begin
                        tlbidx_index <= wr_merged[IDX_W-1:0];
                        tlbidx_ps    <= wr_merged[29:24];
                        tlbidx_ne    <= wr_merged[31];
                    end
                    CSR_TLBEHI:    tlbehi_vppn <= wr_merged[31:13];
                    CSR_ASID:      asid <= wr_merged[9:0];
                    CSR_SAVE0:     save[0] <= wr_merged;
                    CSR_SAVE1:     save[1] <= wr_merged;
                    CSR_SAVE2:     save[2] <= wr_merged;
                    CSR_SAVE3:     save[3] <= wr_merged;
                    CSR_TID:       tid <= wr_merged;
                    CSR_TLBRENTRY: tlbrentry_pa <= wr_merged[31:6];
                    default: ;
                endcase
            end
            if (tlbsrch_we) begin
                tlbidx_ne <= ~tlbsrch_hit;
                if (tlbsrch_hit) tlbidx_index <= tlbsrch_hit_index;
            end
            if (tlbrd_we) begin
                tlbidx_ne   <= ~tlbrd_valid;
                tlbehi_vppn <= tlbrd_valid ? tlbrd_vppn : '0;
                tlbidx_ps   <= tlbrd_valid ? tlbrd_ps   : '0;
                asid        <= tlbrd_valid ? tlbrd_asid : '0;
            end
            if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
                if (estat_ecode == ECODE_TLBR) begin
                    crmd_da <= 1'b0;
                    crmd_pg <= 1'b1;
                end
            end
            if (wb_ex) begin
                prmd_pplv      <= crmd_plv;
                prmd_pie       <= crmd_ie;
                crmd_plv       <= '0;
                crmd_ie        <= 1'b0;
                era            <= wb_pc;
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
                if (ex_badv_pc)      badv <= wb_pc;
                else if (ex_badv_va) badv <= wb_vaddr;
                if (ex_tlbr || ex_page) tlbehi_vppn <= wb_vaddr[31:13];
                if (ex_tlbr) begin
                    crmd_da <= 1'b1;
                    crmd_pg <= 1'b0;
                end
            end
        end
    end

    assign ex_entry = wb_ex ? (ex_tlbr ? {tlbrentry_pa, 6'b0} : {eentry_va, 6'b0}) : era;
    assign has_int  = crmd_ie & |(estat_is & ecfg_lie);

    assign csr_tlbidx_index = tlbidx_index;
    assign csr_asid         = asid;
    assign csr_tlbehi_vppn  = tlbehi_vppn;
    assign csr_crmd_plv     = crmd_plv;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - directed self-checking bench for csr_regfile
module tb_csr_regfile;
    import csr_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex, ertn_flush, ipi_int_in, has_int;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, ex_entry;
    logic [7:0]  hw_int_in;
    logic        tlbsrch_we, tlbsrch_hit, tlbrd_we, tlbrd_valid;
    logic [3:0]  tlbsrch_hit_index, csr_tlbidx_index;
    logic [18:0] tlbrd_vppn, csr_tlbehi_vppn;
    logic [5:0]  tlbrd_ps;
    logic [9:0]  tlbrd_asid, csr_asid;
    logic [1:0]  csr_crmd_plv;

    int n_cmp = 0;
    int n_mis = 0;

    csr_regfile_if bus ();

    csr_regfile #(.TLBNUM(16), .TIMER_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .ex_entry(ex_entry), .has_int(has_int),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .tlbsrch_we(tlbsrch_we), .tlbsrch_hit(tlbsrch_hit), .tlbsrch_hit_index(tlbsrch_hit_index),
        .tlbrd_we(tlbrd_we), .tlbrd_valid(tlbrd_valid), .tlbrd_vppn(tlbrd_vppn),
        .tlbrd_ps(tlbrd_ps), .tlbrd_asid(tlbrd_asid),
        .csr_tlbidx_index(csr_tlbidx_index), .csr_asid(csr_asid),
        .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_crmd_plv(csr_crmd_plv)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        bus.csr_num = num; bus.csr_wmask = mask; bus.csr_wvalue = val; bus.csr_we = 1'b1;
        tick();
        bus.csr_we = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
        bus.csr_num = num;
        #1;
        chk(tag, bus.csr_rvalue, exp);
    endtask

    initial begin
        reset = 1'b1;
        bus.csr_num = '0; bus.csr_we = 1'b0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
        wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
        ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        tlbsrch_we = 1'b0; tlbsrch_hit = 1'b0; tlbsrch_hit_index = '0;
        tlbrd_we = 1'b0; tlbrd_valid = 1'b0; tlbrd_vppn = '0; tlbrd_ps = '0; tlbrd_asid = '0;
        tick(); tick();
        reset = 1'b0;

        csr_chk("reset_crmd", CSR_CRMD, 32'h8);
        csr_chk("reset_estat", CSR_ESTAT, 32'h0);
        chk("reset_has_int", 32'(has_int), 32'h0);
        csr_chk("unimpl_read", 14'h002, 32'h0);

        csr_wr(CSR_SAVE1, 32'hFFFFFFFF, 32'h12345678);
        csr_wr(CSR_SAVE1, 32'h0000FFFF, 32'hDEADBEEF);
        csr_chk("save1_masked", CSR_SAVE1, 32'h1234BEEF);

        csr_wr(CSR_ESTAT, 32'h003F1FFF, 32'hFFFFFFFF);
        csr_chk("estat_ro_bits", CSR_ESTAT, 32'h00000003);
        csr_wr(CSR_ESTAT, 32'h00000003, 32'h0);
        csr_wr(CSR_TVAL, 32'hFFFFFFFF, 32'h55);
        csr_chk("tval_ro", CSR_TVAL, 32'h0);

        // ALE exception then ertn
        csr_wr(CSR_CRMD, 32'hFFFFFFFF, 32'hF);
        csr_wr(CSR_EENTRY, 32'hFFFFFFFF, 32'h1C008000);
        wb_ex = 1'b1; wb_ecode = ECODE_ALE; wb_esubcode = '0; wb_pc = 32'h1C000100; wb_vaddr = 32'h3;
        #1;
        chk("ale_ex_entry", ex_entry, 32'h1C008000);
        tick();
        wb_ex = 1'b0;
        csr_chk("ale_era", CSR_ERA, 32'h1C000100);
        csr_chk("ale_badv", CSR_BADV, 32'h3);
        csr_chk("ale_prmd", CSR_PRMD, 32'h7);
        csr_chk("ale_crmd", CSR_CRMD, 32'h8);
        csr_chk("ale_estat", CSR_ESTAT, 32'h00090000);
        chk("ale_era_entry", ex_entry, 32'h1C000100);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        csr_chk("ertn_crmd", CSR_CRMD, 32'hF);
        chk("ertn_plv", 32'(csr_crmd_plv), 32'h3);
        chk("ertn_ex_entry", ex_entry, 32'h1C000100);

        // periodic timer: InitVal 12
        csr_wr(CSR_ECFG, 32'hFFFFFFFF, 32'h800);
        csr_wr(CSR_TCFG, 32'hFFFFFFFF, 32'hF);
        csr_chk("tval_load", CSR_TVAL, 32'hC);
        repeat (11) tick();
        chk("timer_pre_int", 32'(has_int), 32'h0);
        csr_chk("tval_one", CSR_TVAL, 32'h1);
        tick();
        chk("timer_int", 32'(has_int), 32'h1);
        csr_chk("tval_reload", CSR_TVAL, 32'hC);
        csr_wr(CSR_TICLR, 32'hFFFFFFFF, 32'h1);
        chk("ticlr_has_int", 32'(has_int), 32'h0);
        csr_chk("ticlr_tval", CSR_TVAL, 32'hB);
        csr_chk("ticlr_read", CSR_TICLR, 32'h0);

        // one-shot timer: InitVal 4, holds at 0
        csr_wr(CSR_TCFG, 32'hFFFFFFFF, 32'h5);
        csr_chk("os_load", CSR_TVAL, 32'h4);
        repeat (3) tick();
        chk("os_pre_int", 32'(has_int), 32'h0);
        tick();
        chk("os_int", 32'(has_int), 32'h1);
        repeat (3) tick();
        csr_chk("os_hold0", CSR_TVAL, 32'h0);
        csr_wr(CSR_TICLR, 32'h1, 32'h1);
        repeat (3) tick();
        chk("os_no_refire", 32'(has_int), 32'h0);
        csr_wr(CSR_TCFG, 32'hFFFFFFFF, 32'h0);

        // hardware interrupt line
        csr_wr(CSR_ECFG, 32'hFFFFFFFF, 32'h004);
        hw_int_in = 8'h01;
        tick();
        chk("hw_int", 32'(has_int), 32'h1);
        csr_chk("hw_estat", CSR_ESTAT, 32'h00090004);
        hw_int_in = 8'h00;
        tick();
        chk("hw_int_clear", 32'(has_int), 32'h0);

        // TLBR exception and return
        csr_wr(CSR_TLBRENTRY, 32'hFFFFFFFF, 32'h1C00F000);
        wb_ex = 1'b1; wb_ecode = ECODE_TLBR; wb_pc = 32'h1C000200; wb_vaddr = 32'h00402000;
        #1;
        chk("tlbr_ex_entry", ex_entry, 32'h1C00F000);
        tick();
        wb_ex = 1'b0;
        csr_chk("tlbr_crmd", CSR_CRMD, 32'h8);
        csr_chk("tlbr_badv", CSR_BADV, 32'h00402000);
        chk("tlbr_vppn", 32'(csr_tlbehi_vppn), 32'h201);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        csr_chk("tlbr_ertn_crmd", CSR_CRMD, 32'h17);

        // TLB maintenance
        tlbsrch_we = 1'b1; tlbsrch_hit = 1'b0; tlbsrch_hit_index = 4'd9;
        tick();
        csr_chk("srch_miss", CSR_TLBIDX, 32'h80000000);
        tlbsrch_hit = 1'b1; tlbsrch_hit_index = 4'd5;
        tick();
        tlbsrch_we = 1'b0;
        csr_chk("srch_hit", CSR_TLBIDX, 32'h00000005);
        chk("srch_index", 32'(csr_tlbidx_index), 32'h5);
        tlbrd_we = 1'b1; tlbrd_valid = 1'b1; tlbrd_vppn = 19'h12345; tlbrd_ps = 6'd12; tlbrd_asid = 10'h2A;
        tick();
        csr_chk("rd_tlbidx", CSR_TLBIDX, 32'h0C000005);
        csr_chk("rd_tlbehi", CSR_TLBEHI, 32'h2468A000);
        chk("rd_asid", 32'(csr_asid), 32'h2A);
        tlbrd_valid = 1'b0;
        tick();
        tlbrd_we = 1'b0;
        csr_chk("rdinv_tlbidx", CSR_TLBIDX, 32'h80000005);
        csr_chk("rdinv_tlbehi", CSR_TLBEHI, 32'h0);
        csr_chk("rdinv_asid", CSR_ASID, 32'h0);

        // reset while the timer runs
        csr_wr(CSR_TCFG, 32'hFFFFFFFF, 32'hF);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        csr_chk("rst_crmd", CSR_CRMD, 32'h8);
        csr_chk("rst_tval", CSR_TVAL, 32'h0);
        repeat (3) tick();
        csr_chk("rst_tval_hold", CSR_TVAL, 32'h0);
        csr_chk("rst_tcfg", CSR_TCFG, 32'h0);
        csr_chk("rst_estat", CSR_ESTAT, 32'h0);
        csr_chk("rst_tlbidx", CSR_TLBIDX, 32'h0);
        chk("rst_has_int", 32'(has_int), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
